hw_input_stencil_write_ctrl: RTL and testbench

HW_INPUT_STENCIL_WRITE_CTRL -- requirements
Module: hw_input_stencil_write_ctrl

---
 rtl/hw_input_stencil_write_ctrl_if.sv | 26 ++
 rtl/hw_input_stencil_write_ctrl.sv | 149 ++++++++++++++
 tb/tb_hw_input_stencil_write_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/hw_input_stencil_write_ctrl_if.sv
// Pixel stream in, stencil-buffer write port out, for hw_input_stencil_write_ctrl.
// slave = the controller side, master = the producer/consumer side.
interface hw_input_stencil_write_ctrl_if;
    logic             in_valid;
    logic [15:0]      in_data;
    logic             in_ready;
    logic             op_hcompute_hw_input_stencil_write_wen;
    logic [3:0][15:0] op_hcompute_hw_input_stencil_write_ctrl_vars;
    logic [15:0]      op_hcompute_hw_input_stencil_write;

    modport slave (
        input  in_valid, in_data,
        output in_ready,
        output op_hcompute_hw_input_stencil_write_wen,
        output op_hcompute_hw_input_stencil_write_ctrl_vars,
        output op_hcompute_hw_input_stencil_write
    );

    modport master (
        output in_valid, in_data,
        input  in_ready,
        input  op_hcompute_hw_input_stencil_write_wen,
        input  op_hcompute_hw_input_stencil_write_ctrl_vars,
        input  op_hcompute_hw_input_stencil_write
    );
endinterface

// File: rtl/hw_input_stencil_write_ctrl.sv
// Streams one C x Y x X frame of pixels into the input stencil buffer, x fastest.
// Define HW_INPUT_STENCIL_WRITE_CTRL_STALL_CNT_EN to add the stall_cycles counter output.
module hw_input_stencil_write_ctrl #(
    parameter int X_EXTENT = 64,
    parameter int Y_EXTENT = 64,
    parameter int C_EXTENT = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          start,
    hw_input_stencil_write_ctrl_if.slave  px,
    output logic                          busy,
    output logic                          done
`ifdef HW_INPUT_STENCIL_WRITE_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]                   stall_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, LAST} state_e;

    localparam logic [15:0] X_LAST = 16'(X_EXTENT - 1);
    localparam logic [15:0] Y_LAST = 16'(Y_EXTENT - 1);
    localparam logic [15:0] C_LAST = 16'(C_EXTENT - 1);

    state_e           state_q, state_d;
    logic [15:0]      x_q, x_d, y_q, y_d, c_q, c_d;
    logic             wen_q, wen_d, done_q, done_d;
    logic [15:0]      data_q, data_d;
    logic [3:0][15:0] ctrl_q, ctrl_d;
    logic             in_ready_w, hs;
`ifdef HW_INPUT_STENCIL_WRITE_CTRL_STALL_CNT_EN
    logic [31:0]      stall_q, stall_d;
`endif

    assign in_ready_w = (state_q == RUN) & ~flush;
    assign hs         = px.in_valid & in_ready_w;

    always_comb begin
        // NOTE: every *_d gets a default up front so no path leaves it unassigned (no latches).
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        c_d     = c_q;
        wen_d   = 1'b0;
        done_d  = 1'b0;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
`ifdef HW_INPUT_STENCIL_WRITE_CTRL_STALL_CNT_EN
        stall_d = stall_q;
`endif
        if (flush) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            c_d     = '0;
`ifdef HW_INPUT_STENCIL_WRITE_CTRL_STALL_CNT_EN
            stall_d = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    x_d = '0;
                    y_d = '0;
                    c_d = '0;
                    if (start) begin
                        state_d = RUN;
`ifdef HW_INPUT_STENCIL_WRITE_CTRL_STALL_CNT_EN
                        stall_d = '0;
`endif
                    end
                end
                RUN: begin
                    if (hs) begin
                        wen_d  = 1'b1;
                        data_d = px.in_data;
                        ctrl_d = {x_q, y_q, c_q, 16'd0};
                        // Odometer: each wrap carries into the next-outer index.
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            if (y_q == Y_LAST) begin
                                y_d = '0;
                                if (c_q == C_LAST) begin
                                    c_d     = '0;
                                    state_d = LAST;
                                    done_d  = 1'b1;
                                end else begin
                                    c_d = c_q + 16'd1;
                                end
                            end else begin
                                y_d = y_q + 16'd1;
                            end
                        end else begin
                            x_d = x_q + 16'd1;
                        end
                    end
`ifdef HW_INPUT_STENCIL_WRITE_CTRL_STALL_CNT_EN
                    if (!px.in_valid && stall_q != 32'hFFFF_FFFF) begin
                        stall_d = stall_q + 32'd1;
                    end
`endif
                end
                LAST:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
            wen_q   <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
`ifdef HW_INPUT_STENCIL_WRITE_CTRL_STALL_CNT_EN
            stall_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            wen_q   <= wen_d;
            done_q  <= done_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
`ifdef HW_INPUT_STENCIL_WRITE_CTRL_STALL_CNT_EN
            stall_q <= stall_d;
`endif
        end
    end

    assign px.in_ready = in_ready_w;
    assign px.op_hcompute_hw_input_stencil_write_wen       = wen_q;
    assign px.op_hcompute_hw_input_stencil_write           = data_q;
    assign px.op_hcompute_hw_input_stencil_write_ctrl_vars = ctrl_q;
    assign busy = (state_q == RUN);
    assign done = done_q;
`ifdef HW_INPUT_STENCIL_WRITE_CTRL_STALL_CNT_EN
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_hw_input_stencil_write_ctrl.sv
// Self-checking bench: default 64x64x4 instance plus a 4x2x2 instance, checked against
// a frame-index model (x = k mod X, y = (k / X) mod Y, c = k / (X*Y)).
module tb_hw_input_stencil_write_ctrl;
    localparam int SX = 4, SY = 2, SC = 2;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, start = 1'b0;
    logic tb_valid = 1'b0;
    logic [15:0] tb_data = '0;
    logic busy_b, done_b, busy_s, done_s;
    logic [31:0] stall_b, stall_s;

    hw_input_stencil_write_ctrl_if bif ();
    hw_input_stencil_write_ctrl_if sif ();
    assign bif.in_valid = tb_valid;
    assign bif.in_data  = tb_data;
    assign sif.in_valid = tb_valid;
    assign sif.in_data  = tb_data;

    hw_input_stencil_write_ctrl dut_big (
        .clk(clk), .rst_n(rst_n), .flush(flush), .start(start),
        .px(bif), .busy(busy_b), .done(done_b)
`ifdef HW_INPUT_STENCIL_WRITE_CTRL_STALL_CNT_EN
        , .stall_cycles(stall_b)
`endif
    );

    hw_input_stencil_write_ctrl #(.X_EXTENT(SX), .Y_EXTENT(SY), .C_EXTENT(SC)) dut_small (
        .clk(clk), .rst_n(rst_n), .flush(flush), .start(start),
        .px(sif), .busy(busy_s), .done(done_s)
`ifdef HW_INPUT_STENCIL_WRITE_CTRL_STALL_CNT_EN
        , .stall_cycles(stall_s)
`endif
    );

`ifndef HW_INPUT_STENCIL_WRITE_CTRL_STALL_CNT_EN
    assign stall_b = '0;
    assign stall_s = '0;
`endif

    always #5 clk = ~clk;

    // Observed outputs of whichever instance is under test.
    bit sel = 1'b0;
    logic o_ready, o_wen, o_done, o_busy;
    logic [15:0] o_data;
    logic [3:0][15:0] o_ctrl;
    logic [31:0] o_stall;
    always_comb begin
        if (sel) begin
            o_ready = sif.in_ready; o_wen = sif.op_hcompute_hw_input_stencil_write_wen;
            o_done = done_s; o_busy = busy_s; o_data = sif.op_hcompute_hw_input_stencil_write;
            o_ctrl = sif.op_hcompute_hw_input_stencil_write_ctrl_vars; o_stall = stall_s;
        end else begin
            o_ready = bif.in_ready; o_wen = bif.op_hcompute_hw_input_stencil_write_wen;
            o_done = done_b; o_busy = busy_b; o_data = bif.op_hcompute_hw_input_stencil_write;
            o_ctrl = bif.op_hcompute_hw_input_stencil_write_ctrl_vars; o_stall = stall_b;
        end
    end

    int checks = 0, errors = 0;
    int n_wen = 0, n_done = 0;

    // Reference model: frame extents, running flag, accepted-pixel index.
    int mx = 64, my = 64, mc = 4;
    bit m_run = 0, m_last = 0, m_wen = 0, m_done = 0;
    int m_k = 0;
    logic [15:0] m_data = '0;
    logic [3:0][15:0] m_ctrl = '0;
    logic [31:0] m_stall = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus plus checks of the combinational ready and the registered outputs.
    task automatic cycle(input logic v, input logic [15:0] d, input logic st, input logic fl);
        logic exp_rdy, hs, prev_last;
        int x, y, c;
        tb_valid = v; tb_data = d; start = st; flush = fl;
        #1;
        exp_rdy = m_run && !fl;
        check("in_ready", {63'd0, o_ready}, {63'd0, exp_rdy});
        hs = exp_rdy && v;
        @(posedge clk); #1;
        prev_last = m_last;
        m_last = 0; m_wen = 0; m_done = 0;
        if (fl) begin
            m_run = 0; m_k = 0; m_stall = '0;
        end else if (m_run) begin
            if (!v && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (hs) begin
                x = m_k % mx; y = (m_k / mx) % my; c = m_k / (mx * my);
                m_wen = 1; m_data = d;
                m_ctrl = {16'(x), 16'(y), 16'(c), 16'd0};
                m_k++;
                if (m_k == mx * my * mc) begin
                    m_run = 0; m_last = 1; m_done = 1; m_k = 0;
                end
            end
        end else if (st && !prev_last) begin
            m_run = 1; m_k = 0; m_stall = '0;
        end
        if (o_wen === 1'b1) n_wen++;
        if (o_done === 1'b1) n_done++;
        check("wen",   {63'd0, o_wen},  {63'd0, m_wen});
        check("done",  {63'd0, o_done}, {63'd0, m_done});
        check("busy",  {63'd0, o_busy}, {63'd0, m_run});
        check("data",  {48'd0, o_data}, {48'd0, m_data});
        check("ctrl",  o_ctrl, m_ctrl);
`ifdef HW_INPUT_STENCIL_WRITE_CTRL_STALL_CNT_EN
        check("stall", {32'd0, o_stall}, {32'd0, m_stall});
`endif
        start = 1'b0; flush = 1'b0;
    endtask

    // Asynchronous reset between clock edges; outputs must clear before the next edge.
    task automatic do_reset();
        #2; rst_n = 1'b0; start = 1'b0; flush = 1'b0; #1;
        check("rst_wen",   {63'd0, o_wen},   64'd0);
        check("rst_done",  {63'd0, o_done},  64'd0);
        check("rst_busy",  {63'd0, o_busy},  64'd0);
        check("rst_ready", {63'd0, o_ready}, 64'd0);
        check("rst_data",  {48'd0, o_data},  64'd0);
        check("rst_ctrl",  o_ctrl, 64'd0);
        check("rst_stall", {32'd0, o_stall}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_run = 0; m_last = 0; m_k = 0; m_wen = 0; m_done = 0;
        m_data = '0; m_ctrl = '0; m_stall = '0;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();

        // Full frame, data = pixel index, valid every cycle.
        n_wen = 0; n_done = 0;
        cycle(0, 16'd0, 1, 0);
        for (int i = 0; i < 16384; i++) cycle(1, 16'(i), 0, 0);
        check("f1_writes", n_wen, 16384);
        check("f1_dones", n_done, 1);
        check("f1_last_ctrl", o_ctrl, {16'd63, 16'd63, 16'd3, 16'd0});
        check("f1_last_data", {48'd0, o_data}, 64'd16383);
        cycle(0, 16'd0, 0, 0);
        check("f1_busy_after", {63'd0, o_busy}, 64'd0);

        // Valid toggling 1,0: half the RUN cycles stall.
        n_wen = 0; n_done = 0;
        cycle(0, 16'd0, 1, 0);
        for (int i = 0; i < 32768; i++) cycle(((i % 2) == 0), 16'($urandom), 0, 0);
        check("f2_writes", n_wen, 16384);
        check("f2_dones", n_done, 1);
`ifdef HW_INPUT_STENCIL_WRITE_CTRL_STALL_CNT_EN
        check("f2_stall_at_done", {32'd0, o_stall}, 64'd16383);
`endif

        // Flush after 100 pixels, then restart from the origin.
        n_wen = 0;
        cycle(0, 16'd0, 1, 0);
        for (int i = 0; i < 100; i++) cycle(1, 16'($urandom), 0, 0);
        cycle(1, 16'($urandom), 0, 1);
        check("f3_wen_after_flush", {63'd0, o_wen}, 64'd0);
        check("f3_writes", n_wen, 100);
        cycle(1, 16'($urandom), 0, 0);
        cycle(0, 16'd0, 1, 0);
        cycle(1, 16'hBEEF, 0, 0);
        check("f3_restart_ctrl", o_ctrl, 64'd0);
        check("f3_restart_data", {48'd0, o_data}, 64'hBEEF);
        cycle(0, 16'd0, 0, 1);

        // Start pulsed mid-frame must be ignored.
        n_wen = 0; n_done = 0;
        cycle(0, 16'd0, 1, 0);
        for (int i = 0; i < 16384; i++) cycle(1, 16'($urandom), (i == 500), 0);
        check("f4_writes", n_wen, 16384);
        check("f4_dones", n_done, 1);
        cycle(1, 16'd0, 0, 0);
        check("f4_idle_after", {63'd0, o_busy}, 64'd0);

        // Reset mid-frame with valid still high.
        n_wen = 0;
        cycle(0, 16'd0, 1, 0);
        for (int i = 0; i < 4000; i++) cycle(1, 16'($urandom), 0, 0);
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1, 16'($urandom), 0, 0);
        check("f5_no_wen_after_reset", n_wen, 4000);

        // Small instance, random valid pattern, bounded cycle budget.
        sel = 1'b1; mx = SX; my = SY; mc = SC;
        tb_valid = 1'b0;
        do_reset();
        n_wen = 0; n_done = 0;
        cycle(0, 16'd0, 1, 0);
        for (int i = 0; i < 300 && n_done == 0; i++)
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 0, 0);
        check("s_dones", n_done, 1);
        check("s_writes", n_wen, 16);
        check("s_last_ctrl", o_ctrl, {16'd3, 16'd1, 16'd1, 16'd0});
        cycle(0, 16'd0, 0, 0);
        check("s_busy_after", {63'd0, o_busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
